// File: rtl/pipe_pkg.sv
// Shared EX/MEM definitions: ALU opcodes, stage state encoding, payload layout
// and the overflow-trap opcode classifier.
package pipe_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [0:0] {
    PASS     = 1'b0,
    MUL_WAIT = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] pc_target;
  } ex_mem_payload_t;

  // Only signed arithmetic opcodes turn an ALU overflow into an exception.
  function automatic logic traps_on_overflow(input logic [3:0] ctl);
    logic hit;
    case (ctl)
      ALU_ADD: hit = 1'b1;
      ALU_SUB: hit = 1'b1;
      ALU_MUL: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side request, MEM-side register outputs and redirect/exception signals
// of the EX/MEM stage; slave is the stage view, master the environment view.
interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] alu_out;
  logic        zero;
  logic        overflow;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        exc;
  logic [31:0] epc;

  modport slave (
    input  in_valid, alu_control, alu_out, zero, overflow, store_data, rd,
           reg_write, mem_read, mem_write, branch, pc_plus4, branch_target,
           flush, out_ready,
    output in_ready, out_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, pc_src, pc_target,
           exc, epc
  );

  modport master (
    output in_valid, alu_control, alu_out, zero, overflow, store_data, rd,
           reg_write, mem_read, mem_write, branch, pc_plus4, branch_target,
           flush, out_ready,
    input  in_ready, out_valid, mem_alu_out, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, pc_src, pc_target,
           exc, epc
  );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM payload register: load wins over clear; clear drops valid and the
// redirect but leaves the payload fields untouched.
module ex_mem_reg
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  ex_mem_payload_t d,
  input  logic            d_pc_src,
  output ex_mem_payload_t q,
  output logic            valid,
  output logic            pc_src
);

  // Payload, valid and redirect storage with load/clear/hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q      <= '0;
      valid  <= 1'b0;
      pc_src <= 1'b0;
    end else if (load) begin
      q      <= d;
      valid  <= 1'b1;
      pc_src <= d_pc_src;
    end else if (clear) begin
      valid  <= 1'b0;
      pc_src <= 1'b0;
    end else begin
      q      <= q;
      valid  <= valid;
      pc_src <= pc_src;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: handshake FSM with multiply settle wait, precise
// overflow exception and branch redirect into the MEM-side register.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

  stage_state_e    state_r, state_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;
  logic            ready_s, fire_s, space_s, is_mul_s, ovf_s, exc_r;
  logic [31:0]     epc_r;
  ex_mem_payload_t pay_d_s, pay_q_s;
  logic            out_valid_s, pc_src_s;

  assign space_s  = !out_valid_s | bus.out_ready;
  assign is_mul_s = (bus.alu_control == ALU_MUL);
  assign ovf_s    = bus.overflow & traps_on_overflow(bus.alu_control);
  assign fire_s   = bus.in_valid & ready_s;

  // Next state, settle counter and acceptance.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    ready_s    = 1'b0;
    if (!rst || bus.flush) begin
      state_next = PASS;
      cnt_next   = '0;
    end else begin
      case (state_r)
        PASS: begin
          ready_s = space_s & !is_mul_s;
          if (bus.in_valid & is_mul_s & space_s) begin
            state_next = MUL_WAIT;
            cnt_next   = CNT_W'(MUL_LATENCY - 2);
          end else begin
            state_next = PASS;
          end
        end
        MUL_WAIT: begin
          if (cnt_r != '0) begin
            cnt_next = cnt_r - CNT_W'(1);
          end else begin
            ready_s = space_s;
            if (bus.in_valid & space_s) begin
              state_next = PASS;
            end else begin
              state_next = MUL_WAIT;
            end
          end
        end
        default: begin
          state_next = PASS;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= PASS;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
    end
  end

  // An overflowing arithmetic op enters MEM as a bubble with no side effects.
  always_comb begin
    pay_d_s.alu_out    = bus.alu_out;
    pay_d_s.store_data = bus.store_data;
    pay_d_s.rd         = bus.rd;
    pay_d_s.reg_write  = bus.reg_write & !ovf_s;
    pay_d_s.mem_read   = bus.mem_read & !ovf_s;
    pay_d_s.mem_write  = bus.mem_write & !ovf_s;
    pay_d_s.pc_target  = bus.branch_target;
  end

  ex_mem_reg u_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (fire_s),
    .clear    (bus.flush | bus.out_ready),
    .d        (pay_d_s),
    .d_pc_src (bus.branch & bus.zero & !ovf_s),
    .q        (pay_q_s),
    .valid    (out_valid_s),
    .pc_src   (pc_src_s)
  );

  // Exception pulse and faulting PC capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      exc_r <= 1'b0;
      epc_r <= 32'd0;
    end else begin
      exc_r <= fire_s & ovf_s;
      if (fire_s & ovf_s) begin
        epc_r <= bus.pc_plus4 - 32'd4;
      end else begin
        epc_r <= epc_r;
      end
    end
  end

  assign bus.in_ready       = ready_s;
  assign bus.out_valid      = out_valid_s;
  assign bus.mem_alu_out    = pay_q_s.alu_out;
  assign bus.mem_store_data = pay_q_s.store_data;
  assign bus.mem_rd         = pay_q_s.rd;
  assign bus.mem_reg_write  = pay_q_s.reg_write;
  assign bus.mem_mem_read   = pay_q_s.mem_read;
  assign bus.mem_mem_write  = pay_q_s.mem_write;
  assign bus.pc_src         = pc_src_s;
  assign bus.pc_target      = pay_q_s.pc_target;
  assign bus.exc            = exc_r;
  assign bus.epc            = epc_r;

endmodule
